div_clk_meter: RTL

Consumer-side companion to the clock dividers. It samples a divided clock with the source clock and measures the divided clock's period and high time in source-clock cycles, one report per period. The bench uses it as a self-checking monitor for dividers (integer and half-integer). It is also synthesizable as an on-chip divider health check.

---
 rtl/div_meas_pkg.sv | 14 +
 rtl/div_clk_meter_sync_rise_det.sv | 35 +++
 rtl/div_clk_meter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/div_meas_pkg.sv
// Shared types and default sizing for the divided-clock period/high-time meter.
package div_meas_pkg;

  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_TIMEOUT     = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } meas_state_t;

endpackage

// File: rtl/div_clk_meter_sync_rise_det.sv
// Synchronizer chain for the asynchronous divided clock plus a delay flop
// that turns the synchronized level into a single-cycle rising-edge strobe.
module sync_rise_det
  import div_meas_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic div_clk_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Shift the raw input through the synchronizer, then delay one more cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising edge is the synchronized level high while its delayed copy is low.
  always_comb begin
    sync_out = sync_q[SYNC_STAGES-1];
    rise     = sync_q[SYNC_STAGES-1] & ~dly_q;
  end

endmodule

// File: rtl/div_clk_meter.sv
// Measures period and high time of a divided clock in source-clock cycles,
// reporting once per period, and flags a missing edge after TIMEOUT cycles.
module div_clk_meter
  import div_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             no_edge
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

  logic             sync_out;
  logic             rise;
  meas_state_t      state;
  meas_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic             report;
  logic             restart;
  logic             timeout_hit;
  logic             count_en;

  sync_rise_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_rise_det (
    .clk        (clk),
    .rst        (rst),
    .div_clk_in (div_clk_in),
    .sync_out   (sync_out),
    .rise       (rise)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: enable low overrides everything; a rise beats the timeout.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     state_nxt = rise ? MEAS : ARM;
        MEAS: begin
          if (!rise && (cnt == TIMEOUT_CNT)) begin
            state_nxt = ARM;
          end else begin
            state_nxt = MEAS;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-cycle control decoded from state, enable and the edge strobe.
  always_comb begin
    report      = enable && (state == MEAS) && rise;
    restart     = enable && (state == ARM) && rise;
    timeout_hit = enable && (state == MEAS) && !rise && (cnt == TIMEOUT_CNT);
    count_en    = enable && (state == MEAS) && !rise && (cnt != TIMEOUT_CNT);
  end

  // Period and high-time counters; cnt is capped by the timeout so never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      hi_cnt <= '0;
    end else if (!enable || (state == IDLE)) begin
      cnt    <= '0;
      hi_cnt <= '0;
    end else if (report || restart) begin
      // The rise cycle itself is the first sample of the new period and is high.
      cnt    <= ONE_CNT;
      hi_cnt <= ONE_CNT;
    end else if (timeout_hit) begin
      cnt    <= '0;
      hi_cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + ONE_CNT;
      if (sync_out) begin
        hi_cnt <= hi_cnt + ONE_CNT;
      end
    end
  end

  // Reported results, valid strobe and the sticky missing-edge flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      no_edge    <= 1'b0;
    end else begin
      meas_valid <= report;
      if (report) begin
        period    <= cnt;
        high_time <= hi_cnt;
      end
      if (!enable || report) begin
        no_edge <= 1'b0;
      end else if (timeout_hit) begin
        no_edge <= 1'b1;
      end
    end
  end

endmodule
